// File: rtl/iqdemod_pkg.sv
// Shared defaults and FSM state encoding for the I/Q demodulating integrator.
package iqdemod_pkg;

  localparam int NSLICE_DEF = 4;
  localparam int DW_DEF     = 16;
  localparam int ACCW_DEF   = 48;
  localparam int CNTW_DEF   = 24;
  localparam int SUMW       = 2*DW_DEF + $clog2(NSLICE_DEF);

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    ACC,
    DONE
  } state_t;

endpackage

// File: rtl/iqdemod_slicemix.sv
// One ADC slice mixed with its LO pair: registered adc*cos and -(adc*sin).
module iqdemod_slicemix
  import iqdemod_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic signed [DW-1:0]   adc,
  input  logic signed [DW-1:0]   cos_lo,
  input  logic signed [DW-1:0]   sin_lo,
  output logic signed [2*DW-1:0] pi,
  output logic signed [2*DW-1:0] pq
);

  logic signed [2*DW-1:0] mul_i;
  logic signed [2*DW-1:0] mul_q;

  assign mul_i = (2*DW)'(adc) * (2*DW)'(cos_lo);
  assign mul_q = -((2*DW)'(adc) * (2*DW)'(sin_lo));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pi <= '0;
      pq <= '0;
    end else begin
      pi <= mul_i;
      pq <= mul_q;
    end
  end

endmodule

// File: rtl/iqdemod_acc.sv
// Mixes NSLICE ADC samples per clk with the LO, integrates over the gatein window and
// hands one I/Q result out via valid/ready. Define DEMOD_SAT_EN for saturating accumulation.
module iqdemod_acc
  import iqdemod_pkg::*;
#(
  parameter int NSLICE = NSLICE_DEF,
  parameter int DW     = DW_DEF,
  parameter int ACCW   = ACCW_DEF,
  parameter int CNTW   = CNTW_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     gatein,
  input  logic [NSLICE*DW-1:0]     adcx16,
  input  logic [NSLICE*32-1:0]     locossin32,
  output logic signed [ACCW-1:0]   acc_i,
  output logic signed [ACCW-1:0]   acc_q,
  output logic [CNTW-1:0]          nsamp,
  output logic                     acc_valid,
  input  logic                     acc_ready,
  output logic                     overrun,
  output logic                     sat
);

  localparam int PW = 2*DW;
  localparam int SW = PW + $clog2(NSLICE);

  logic signed [PW-1:0]   pi [NSLICE];
  logic signed [PW-1:0]   pq [NSLICE];
  logic signed [SW-1:0]   sum_i_c, sum_q_c, si, sq;
  logic signed [ACCW-1:0] si_x, sq_x;
  logic signed [ACCW-1:0] acc_sum_i, acc_sum_q, add_i, add_q;
  logic [CNTW-1:0]        cnt;
  logic                   g1, gd;
  logic [1:0]             fill;
  state_t                 state, state_n;
  logic                   load, accum, xfer;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    iqdemod_slicemix #(.DW(DW)) u_mix (
      .clk    (clk),
      .resetn (resetn),
      .adc    (adcx16[DW*k +: DW]),
      .cos_lo (locossin32[32*k+16 +: DW]),
      .sin_lo (locossin32[32*k +: DW]),
      .pi     (pi[k]),
      .pq     (pq[k])
    );
  end

  always_comb begin
    sum_i_c = '0;
    sum_q_c = '0;
    for (int k = 0; k < NSLICE; k++) begin
      sum_i_c = sum_i_c + SW'(pi[k]);
      sum_q_c = sum_q_c + SW'(pq[k]);
    end
  end

  // fill marks when gd carries a real gatein sample rather than the post-reset zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      si   <= '0;
      sq   <= '0;
      g1   <= 1'b0;
      gd   <= 1'b0;
      fill <= '0;
    end else begin
      si   <= sum_i_c;
      sq   <= sum_q_c;
      g1   <= gatein;
      gd   <= g1;
      fill <= {fill[0], 1'b1};
    end
  end

  assign si_x = ACCW'(si);
  assign sq_x = ACCW'(sq);

`ifdef DEMOD_SAT_EN
  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
  logic signed [ACCW:0] wide_i, wide_q;
  logic                 ovf_i, ovf_q;

  always_comb begin
    wide_i = {acc_sum_i[ACCW-1], acc_sum_i} + {si_x[ACCW-1], si_x};
    wide_q = {acc_sum_q[ACCW-1], acc_sum_q} + {sq_x[ACCW-1], sq_x};
    ovf_i  = wide_i[ACCW] ^ wide_i[ACCW-1];
    ovf_q  = wide_q[ACCW] ^ wide_q[ACCW-1];
    add_i  = ovf_i ? (wide_i[ACCW] ? ACC_MIN : ACC_MAX) : wide_i[ACCW-1:0];
    add_q  = ovf_q ? (wide_q[ACCW] ? ACC_MIN : ACC_MAX) : wide_q[ACCW-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sat <= 1'b0;
    else if (accum && (ovf_i || ovf_q)) sat <= 1'b1;
  end
`else
  assign add_i = acc_sum_i + si_x;
  assign add_q = acc_sum_q + sq_x;
  assign sat   = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ARM;
    else         state <= state_n;
  end

  // DONE both publishes the finished window and may start the next one
  always_comb begin
    state_n = state;
    load    = 1'b0;
    accum   = 1'b0;
    xfer    = 1'b0;
    case (state)
      ARM:  if (fill[1] && !gd) state_n = IDLE;
      IDLE: if (gd) begin
              state_n = ACC;
              load    = 1'b1;
            end
      ACC:  if (gd) accum = 1'b1;
            else    state_n = DONE;
      DONE: begin
              xfer    = 1'b1;
              load    = gd;
              state_n = gd ? ACC : IDLE;
            end
      default: state_n = ARM;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_sum_i <= '0;
      acc_sum_q <= '0;
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      nsamp     <= '0;
      acc_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        acc_sum_i <= si_x;
        acc_sum_q <= sq_x;
        cnt       <= CNTW'(1);
      end else if (accum) begin
        acc_sum_i <= add_i;
        acc_sum_q <= add_q;
        if (cnt != {CNTW{1'b1}}) cnt <= cnt + CNTW'(1);
      end
      if (xfer) begin
        if (!acc_valid || acc_ready) begin
          acc_i     <= acc_sum_i;
          acc_q     <= acc_sum_q;
          nsamp     <= cnt;
          acc_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (acc_valid && acc_ready) begin
        acc_valid <= 1'b0;
      end
    end
  end

endmodule
